hazard_unit: RTL
================

Name: hazard_unit

Overview:
- Pipeline hazard unit for the 5-stage MIPS core.
- Consumes the per-stage control bits that the pipelined controller produces (branchD, regwriteE/M/W, memtoregE/M) and the register specifiers from the datapath.
- Returns forwarding selects, stall enables, and the flushE/flushM bubbles that feed back into the controller and datapath pipeline registers.
- Also sequences a multi-cycle divide held in the Execute stage, and keeps a saturating stall-cycle performance counter.

Parameters:
- DIV_CYCLES, 32, total cycles a divide occupies Execute (must be >= 2)
- CNT_W, 32, width of the stall performance counter

Ports:
- clk input 1 system clock, rising edge
- rst input 1 asynchronous active-high reset
- rsD input 5 rs specifier, Decode
- rtD input 5 rt specifier, Decode
- branchD input 1 branch in Decode
- rsE input 5 rs specifier, Execute
- rtE input 5 rt specifier, Execute
- writeregE input 5 destination register, Execute
- regwriteE input 1 Execute writes register file
- memtoregE input 1 Execute is a load
- divstartE input 1 divide instruction present in Execute
- writeregM input 5 destination register, Memory
- regwriteM input 1 Memory writes register file
- memtoregM input 1 Memory is a load
- writeregW input 5 destination register, Writeback
- regwriteW input 1 Writeback writes register file
- forwardAD output 1 Decode rs comparator takes ALU result from Memory
- forwardBD output 1 Decode rt comparator takes ALU result from Memory
- forwardAE output 2 Execute srcA select: 00 regfile, 01 Writeback result, 10 Memory ALU result
- forwardBE output 2 Execute srcB select, same encoding
- stallF output 1 hold PC
- stallD output 1 hold IF/ID register
- stallE output 1 hold ID/EX register
- flushE output 1 clear ID/EX register (bubble)
- flushM output 1 clear EX/MEM register (bubble)
- divdoneE output 1 one-cycle pulse on the final divide cycle
- stallcnt output CNT_W cycles with stallD asserted

Behaviour:
- Forwarding (combinational):
  - forwardAE = 10 if rsE != 0 && rsE == writeregM && regwriteM.
  - Otherwise forwardAE = 01 if rsE != 0 && rsE == writeregW && regwriteW.
  - Otherwise 00. Memory takes priority over Writeback.
  - forwardBE is identical, using rtE.
- Decode forwarding: forwardAD = rsD != 0 && rsD == writeregM && regwriteM; forwardBD likewise with rtD.
- lwstall = memtoregE && writeregE != 0 && (writeregE == rsD || writeregE == rtD).
- branchstall = branchD && ( (regwriteE && writeregE != 0 && writeregE in {rsD, rtD}) || (memtoregM && writeregM != 0 && writeregM in {rsD, rtD}) ).
- Divide FSM, states IDLE and BUSY, with down-counter cnt of width clog2(DIV_CYCLES):
  - IDLE & divstartE: divstall = 1, cnt <= DIV_CYCLES-2, go to BUSY.
  - BUSY & cnt != 0: divstall = 1, cnt <= cnt-1.
  - BUSY & cnt == 0: divstall = 0, divdoneE = 1, go to IDLE. This holds even if divstartE is still high.
  - A divide therefore occupies Execute for exactly DIV_CYCLES cycles.
  - A back-to-back divide starts in the cycle after divdoneE.
- Stall outputs:
  - stallF = stallD = lwstall | branchstall | divstall.
  - stallE = divstall.
  - flushM = divstall, so Memory receives bubbles while the divide is held.
  - flushE = (lwstall | branchstall) & ~divstall. A held Execute stage is never flushed.
- stallcnt:
  - Increments on every rising edge where stallD = 1.
  - Saturates at all-ones and does not wrap.
- Reset (asynchronous):
  - state = IDLE, cnt = 0, stallcnt = 0, divdoneE = 0.
  - Reset mid-divide aborts it: divstall drops immediately.
  - Combinational outputs follow their inputs, with divstall forced to 0 while rst = 1.
- Latency: every output except stallcnt is combinational from the current inputs and FSM state. stallcnt reflects stallD from the previous cycle.

Test Plan:
- Forwarding priority: rsE=5, writeregM=5 regwriteM=1, writeregW=5 regwriteW=1 -> forwardAE=10. With rsE=0, same writes -> forwardAE=00. With regwriteM=0 -> forwardAE=01.
- Load-use: memtoregE=1, writeregE=8, rtD=8 -> stallF=stallD=flushE=1, stallE=0. Next cycle with memtoregE=0 -> all zero. stallcnt increments by 1.
- Branch hazard: branchD=1, regwriteE=1, writeregE=3, rsD=3 -> stall and flushE. Then memtoregM=1, writeregM=3 -> stall persists. Then regwriteM=1, memtoregM=0 -> forwardAD=1, no stall.
- Divide, DIV_CYCLES=4: divstartE held high -> stallE=flushM=1 for 3 cycles, then divdoneE=1 with stalls low. A second divide immediately after -> another 4-cycle sequence.
- Divide overlapping a load-use: divstall plus lwstall -> flushE=0, stallE=1, stallD=1.
- Reset mid-divide (cycle 2 of 32) -> stallE, flushM, stallcnt drop to 0 asynchronously; FSM is IDLE after release.
- Saturation: CNT_W=4, stallD held for 20 cycles -> stallcnt=15.

Source files
------------

// File: rtl/hazard_unit.sv
// Pipeline hazard unit for the 5-stage MIPS core.
// Resolves data hazards with forwarding where it can. Where it cannot, it
// stalls and flushes. It also holds a multi-cycle divide in Execute and
// counts the cycles in which Decode is stalled.
//
// Ports:
//   clk, rst                 rising-edge clock, async active-high reset
//   rsD, rtD, branchD        Decode source specifiers and branch flag
//   rsE, rtE, writeregE      Execute specifiers and destination
//   regwriteE, memtoregE     Execute writes regfile / is a load
//   divstartE                divide instruction present in Execute
//   writeregM, regwriteM,    Memory destination, regfile write, load
//   memtoregM
//   writeregW, regwriteW     Writeback destination and regfile write
//   forwardAD/BD             Decode comparators take Memory ALU result
//   forwardAE/BE             Execute operand select (00 rf, 01 W, 10 M)
//   stallF/D/E, flushE/M     pipeline register hold / bubble controls
//   divdoneE                 pulse on the final divide cycle
//   stallcnt                 saturating count of stallD cycles
module hazard_unit #(
  parameter int unsigned DIV_CYCLES = 32,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rsD,
  input  logic [4:0]       rtD,
  input  logic             branchD,
  input  logic [4:0]       rsE,
  input  logic [4:0]       rtE,
  input  logic [4:0]       writeregE,
  input  logic             regwriteE,
  input  logic             memtoregE,
  input  logic             divstartE,
  input  logic [4:0]       writeregM,
  input  logic             regwriteM,
  input  logic             memtoregM,
  input  logic [4:0]       writeregW,
  input  logic             regwriteW,
  output logic             forwardAD,
  output logic             forwardBD,
  output logic [1:0]       forwardAE,
  output logic [1:0]       forwardBE,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             flushE,
  output logic             flushM,
  output logic             divdoneE,
  output logic [CNT_W-1:0] stallcnt
);

  localparam int unsigned CW = $clog2(DIV_CYCLES);

  typedef enum logic {IDLE, BUSY} div_state_e;

  div_state_e       state_q;
  logic [CW-1:0]    cnt_q;
  logic [CNT_W-1:0] stallcnt_q;
  logic [CNT_W-1:0] stallcnt_d;
  logic             lwstall;
  logic             branchstall;
  logic             divstall;
  logic             hitE_d;
  logic             hitM_d;

  // Execute operand forwarding; Memory is newer than Writeback so it wins
  always_comb begin
    forwardAE = 2'b00;
    forwardBE = 2'b00;
    if (rsE != 5'd0 && rsE == writeregM && regwriteM)      forwardAE = 2'b10;
    else if (rsE != 5'd0 && rsE == writeregW && regwriteW) forwardAE = 2'b01;
    if (rtE != 5'd0 && rtE == writeregM && regwriteM)      forwardBE = 2'b10;
    else if (rtE != 5'd0 && rtE == writeregW && regwriteW) forwardBE = 2'b01;
  end

  // Decode branch comparator forwarding from Memory
  assign forwardAD = (rsD != 5'd0) && (rsD == writeregM) && regwriteM;
  assign forwardBD = (rtD != 5'd0) && (rtD == writeregM) && regwriteM;

  // Load result not available until after Memory: stall the consumer
  assign lwstall = memtoregE && (writeregE != 5'd0) &&
                   ((writeregE == rsD) || (writeregE == rtD));

  // Branch resolves in Decode, so an ALU result still in Execute or a
  // load still in Memory cannot be forwarded in time
  assign hitE_d = regwriteE && (writeregE != 5'd0) &&
                  ((writeregE == rsD) || (writeregE == rtD));
  assign hitM_d = memtoregM && (writeregM != 5'd0) &&
                  ((writeregM == rsD) || (writeregM == rtD));
  assign branchstall = branchD && (hitE_d || hitM_d);

  // Divide hold: stalled on every cycle except the last one
  assign divstall = !rst && (((state_q == IDLE) && divstartE) ||
                             ((state_q == BUSY) && (cnt_q != '0)));
  assign divdoneE = (state_q == BUSY) && (cnt_q == '0);

  assign stallF = lwstall || branchstall || divstall;
  assign stallD = stallF;
  assign stallE = divstall;
  assign flushM = divstall;
  assign flushE = (lwstall || branchstall) && !divstall;

  // Divide sequencer; the start cycle counts as the first divide cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (divstartE) begin
            state_q <= BUSY;
            cnt_q   <= CW'(DIV_CYCLES - 2);
          end
        end
        BUSY: begin
          if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
          else             state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Saturating stall-cycle counter
  assign stallcnt_d = (stallD && (stallcnt_q != '1)) ? stallcnt_q + CNT_W'(1)
                                                     : stallcnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stallcnt_q <= '0;
    else     stallcnt_q <= stallcnt_d;
  end

  assign stallcnt = stallcnt_q;

endmodule
